// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter sharing one downstream APB completer path between NUM_REQ requesters.
// Optional ACCESS-phase timeout with slave error is enabled by defining APB_ARB_TIMEOUT_EN.
module apb_rr_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          APB_PCLK,
    input  logic                          APB_PRESETn,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_paddr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_pdata,
    input  logic [NUM_REQ-1:0]            req_pwrite,
    input  logic [NUM_REQ*4-1:0]          req_pstb,
    input  logic [NUM_REQ-1:0]            req_psel,
    input  logic [NUM_REQ-1:0]            req_penable,
    output logic [DATA_WIDTH-1:0]         req_prdata,
    output logic [NUM_REQ-1:0]            req_pready,
    output logic [NUM_REQ-1:0]            req_pslverr,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pdata,
    output logic                          pwrite,
    output logic [3:0]                    pstb,
    output logic                          psel,
    output logic                          penable,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      rr_pick;
    logic               psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               tmo;
    logic               done;
    logic [NUM_REQ-1:0] grant_oh;

    // The requester's own access-phase flag carries no information we need.
    logic unused_penable;
    assign unused_penable = ^req_penable;

    // Search starts one past the last winner; lower offsets override higher ones.
    always_comb begin
        int idx;
        idx     = 0;
        rr_pick = last_q;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(last_q) + 1 + k) % NUM_REQ;
            if (req_psel[idx]) rr_pick = GW'(idx);
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW0 = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW  = (TW0 < 8) ? 8 : ((TW0 > 32) ? 32 : TW0);

    logic [TW-1:0] tcnt_q, tcnt_d;

    // tcnt_q counts waited cycles before this one, so the limit hits in the last allowed cycle.
    assign tmo = (state_q == S_ACCESS) && !pready && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tcnt_d = tcnt_q;
        if (state_q == S_SETUP)                 tcnt_d = '0;
        else if (state_q == S_ACCESS && !pready) tcnt_d = tcnt_q + TW'(1);
    end

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) tcnt_q <= '0;
        else              tcnt_q <= tcnt_d;
    end
`else
    localparam int unused_timeout_cfg = TIMEOUT_CYCLES;
    assign tmo = 1'b0;
`endif

    assign done = (state_q == S_ACCESS) && (pready || tmo);

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        case (state_q)
            S_IDLE: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                if (|req_psel) begin
                    grant_d = rr_pick;
                    state_d = S_SETUP;
                    psel_d  = 1'b1;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                psel_d    = 1'b1;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (done) begin
                    last_d    = grant_q;
                    state_d   = S_IDLE;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge APB_PCLK or negedge APB_PRESETn) begin
        if (!APB_PRESETn) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            last_q    <= GW'(NUM_REQ - 1);
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
        end
    end

    assign grant_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_q;
    assign req_pready  = done ? grant_oh : '0;
    assign req_pslverr = tmo ? grant_oh : '0;
    assign req_prdata  = prdata;

    assign paddr   = req_paddr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    assign pdata   = req_pdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign pwrite  = req_pwrite[grant_q];
    assign pstb    = req_pstb[int'(grant_q)*4 +: 4];
    assign psel    = psel_q;
    assign penable = penable_q;
endmodule
